wb_dbus_decoder: RTL
====================

// Module: wb_dbus_decoder
// PURPOSE
//   Single-master, three-slave Wishbone address decoder and bus-timeout monitor.
//   It sits between the CPU data-bus master and its slaves: slave 0 is data RAM
//   (the default target), slave 1 is IO window 1 and slave 2 is IO window 2.
//   Each transfer is routed to exactly one slave. A slave that never acks is
//   terminated with a one-cycle error pulse to the master.
// PARAMETERS
//   IO1_BASE   32'h3000_0000  byte base address of IO window 1 (slave 1)
//   IO2_BASE   32'h4000_0000  byte base address of IO window 2 (slave 2)
//   IO_SPAN    16             bytes decoded per IO window (>=4, multiple of 4)
//   TIMEOUT    255            max cycles in BUSY before error (>=2)
// PORTS
//   wb_clk_i   in   1   clock
//   wb_rst_i   in   1   asynchronous active-high reset
//   m_adr_i    in   32  master byte address
//   m_dat_i    in   32  master write data
//   m_sel_i    in   4   master byte selects
//   m_we_i     in   1   master write enable
//   m_cyc_i    in   1   master cycle
//   m_stb_i    in   1   master strobe
//   m_dat_o    out  32  read data from the selected slave
//   m_ack_o    out  1   ack from the selected slave
//   m_err_o    out  1   bus error (timeout), one-cycle pulse
//   s_adr_o    out  32  shared slave address (= m_adr_i)
//   s_dat_o    out  32  shared slave write data (= m_dat_i)
//   s_sel_o    out  4   shared slave byte selects (= m_sel_i)
//   s_we_o     out  1   shared slave write enable (= m_we_i)
//   s_cyc_o    out  3   per-slave cycle, one-hot or zero; bit n = slave n
//   s_stb_o    out  3   per-slave strobe, one-hot or zero
//   s_ack_i    in   3   per-slave ack
//   s_dat_i    in   96  per-slave read data; slave n in [32n+31:32n]
// BEHAVIOUR
//   - Reset (async, any time): state=IDLE, sel=0, cnt=0, m_err_o=0. All outputs
//     derived from these are 0: s_cyc_o, s_stb_o, m_ack_o, m_dat_o.
//   - Decode is combinational on m_adr_i:
//     - hitN = (m_adr_i - IOn_BASE) < IO_SPAN, computed as unsigned 32-bit.
//       Addresses below a base wrap to a large value and miss.
//     - If hit1 and hit2 are both true, slave 1 wins.
//     - If neither hits, slave 0 is selected. There is no decode error.
//   - IDLE: on m_cyc_i & m_stb_i, register the one-hot sel and clear cnt. The next
//     state is BUSY. This adds one cycle of request latency.
//   - BUSY:
//     - s_cyc_o = sel & {3{m_cyc_i}}; s_stb_o = sel & {3{m_stb_i}}.
//     - m_ack_o = |(s_ack_i & sel) & m_cyc_i, combinational.
//     - m_dat_o = mux of s_dat_i by sel, combinational; 0 when sel=0.
//     - On m_ack_o: go to IDLE, sel<=0. A new request can be decoded the
//       following cycle (2 cycles minimum between back-to-back starts).
//     - If m_cyc_i falls (abort): strobes drop the same cycle, state goes to
//       IDLE, sel<=0, and no ack or err is generated.
//     - Otherwise cnt increments each cycle. When cnt==TIMEOUT-1 and there is no
//       ack, go to ERR with sel<=0.
//     - Ack in the same cycle as the timeout: the ack wins and there is no err.
//   - ERR: m_err_o=1 for exactly one cycle (registered). All strobes are 0.
//     Go to IDLE next. Slave acks arriving in ERR or IDLE are ignored.
//   - cnt width = $clog2(TIMEOUT+1). cnt saturates and never wraps.
//   - Shared s_adr/s_dat/s_sel/s_we are pure pass-through at all times.
// TESTING
//   1. Write 0xDEADBEEF to 0x0000_0100, sel=4'hF, slave acks 1 cycle later:
//      s_stb_o=3'b001 one cycle after m_stb_i; m_ack_o follows the slave ack;
//      readback returns 0xDEADBEEF.
//   2. Read 0x3000_0004, slave 1 drives 0x1234_5678 with ack: s_stb_o=3'b010;
//      m_dat_o=0x1234_5678 while m_ack_o=1. Same test at 0x4000_000C gives
//      s_stb_o=3'b100.
//   3. Boundaries with IO_SPAN=16: 0x2FFF_FFFC and 0x3000_0010 go to slave 0;
//      0x3000_000C goes to slave 1. With overlapping bases, slave 1 wins.
//   4. TIMEOUT=8, slave 2 never acks: m_err_o pulses high for 1 cycle, 8 cycles
//      after BUSY entry. s_stb_o=0 during that pulse and m_ack_o never rises.
//      A late ack 2 cycles later is ignored.
//   5. Master drops m_cyc_i in the 3rd BUSY cycle: s_cyc_o=0 the same cycle and
//      IDLE next. A slave ack 1 cycle later does not reach m_ack_o.
//   6. Assert wb_rst_i mid-BUSY (off clock edge): s_cyc_o, s_stb_o, m_ack_o and
//      m_err_o go to 0 immediately. The first request after release decodes
//      normally.

Source files
------------

// File: rtl/wb_dbus_decoder.sv
// Single-master Wishbone data-bus decoder: RAM (slave 0, default) plus two IO windows, with a bus-timeout monitor.
// Latency: one registered decode cycle before slave strobes. Ack and read data return combinationally. Slave stalls are bounded by TIMEOUT.
module wb_dbus_decoder #(
    parameter logic [31:0] IO1_BASE = 32'h3000_0000,
    parameter logic [31:0] IO2_BASE = 32'h4000_0000,
    parameter int unsigned IO_SPAN  = 16,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    input  logic [3:0]  m_sel_i,
    input  logic        m_we_i,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    output logic [31:0] m_dat_o,
    output logic        m_ack_o,
    output logic        m_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic [2:0]  s_cyc_o,
    output logic [2:0]  s_stb_o,
    input  logic [2:0]  s_ack_i,
    input  logic [95:0] s_dat_i
);
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [31:0]   SPAN     = 32'(IO_SPAN);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t        state, state_nxt;
    logic [2:0]    sel, sel_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          err_nxt;
    logic [31:0]   off1, off2;
    logic          hit1, hit2;
    logic [2:0]    dec_sel;

    // Unsigned offset compare: addresses below a base wrap high and miss.
    assign off1 = m_adr_i - IO1_BASE;
    assign off2 = m_adr_i - IO2_BASE;
    assign hit1 = off1 < SPAN;
    assign hit2 = off2 < SPAN;

    always_comb begin
        dec_sel = 3'b001;
        if (hit1)
            dec_sel = 3'b010;
        else if (hit2)
            dec_sel = 3'b100;
    end

    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;
    assign s_we_o  = m_we_i;

    // sel is only non-zero in BUSY, so strobes and acks are dead in IDLE and ERR.
    assign s_cyc_o = sel & {3{m_cyc_i}};
    assign s_stb_o = sel & {3{m_stb_i & m_cyc_i}};
    assign m_ack_o = (|(s_ack_i & sel)) & m_cyc_i;

    always_comb begin
        m_dat_o = '0;
        for (int n = 0; n < 3; n++)
            if (sel[n])
                m_dat_o = m_dat_o | s_dat_i[32*n +: 32];
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    sel_nxt   = dec_sel;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Abort and ack both beat the timeout in the same cycle.
                if (!m_cyc_i || m_ack_o) begin
                    sel_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    sel_nxt   = '0;
                    err_nxt   = 1'b1;
                    state_nxt = ERR;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ERR: begin
                state_nxt = IDLE;
            end
            default: begin
                sel_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            sel     <= '0;
            cnt     <= '0;
            m_err_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            cnt     <= cnt_nxt;
            m_err_o <= err_nxt;
        end
    end
endmodule
